fast_frame_ctrl: RTL and testbench



---
 rtl/fast_frame_ctrl_pkg.sv | 28 ++
 rtl/fast_frame_ctrl_if.sv | 31 +++
 rtl/fast_frame_ctrl_fifo.sv | 63 ++++++
 rtl/fast_frame_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_fast_frame_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fast_frame_ctrl_pkg.sv
// fast_ctrl_pkg: shared types and widths for the FAST frame controller.
//   fast_ctrl_state_e : controller FSM states
//   corner_t          : one corner result {x, y, score} as stored in the output FIFO
//   *_CNT_W           : widths of the pixel, drain and statistics counters
package fast_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_FLUSH,
    ST_DONE
  } fast_ctrl_state_e;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [12:0] score;
  } corner_t;

  // 20 bits covers frames up to 1M pixels, 16 bits covers drain lengths to 64K.
  localparam int PIX_CNT_W    = 20;
  localparam int DRAIN_CNT_W  = 16;
  localparam int CORNER_CNT_W = 20;
  localparam int STALL_CNT_W  = 32;

endpackage

// File: rtl/fast_frame_ctrl_if.sv
// fast_frame_ctrl_if: the two streaming handshakes around the frame controller.
//   s_pix_data/s_pix_valid/s_pix_ready : raster pixel stream into the controller
//   m_valid/m_ready/m_x/m_y/m_score    : corner results out of the controller
// Modports:
//   master : environment side (drives pixels, consumes corners)
//   slave  : controller side
interface fast_frame_ctrl_if #(
  parameter int PIXEL_WIDTH = 8
);

  logic [PIXEL_WIDTH-1:0] s_pix_data;
  logic                   s_pix_valid;
  logic                   s_pix_ready;

  logic                   m_valid;
  logic                   m_ready;
  logic [9:0]             m_x;
  logic [9:0]             m_y;
  logic [12:0]            m_score;

  modport master (
    output s_pix_data, s_pix_valid, m_ready,
    input  s_pix_ready, m_valid, m_x, m_y, m_score
  );

  modport slave (
    input  s_pix_data, s_pix_valid, m_ready,
    output s_pix_ready, m_valid, m_x, m_y, m_score
  );

endinterface

// File: rtl/fast_frame_ctrl_fifo.sv
// fast_corner_fifo: synchronous first-word-fall-through FIFO of corner_t.
//   clk, rst     : clock, synchronous active-high reset (pointers/level only)
//   flush        : synchronous empty
//   push/wr_data : write port (ignored when full)
//   pop          : read acknowledge (ignored when empty)
//   rd_data      : head entry, valid whenever empty=0
//   empty        : no entries
//   free_cnt     : number of free entries, from the registered level
module fast_corner_fifo
  import fast_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        push,
  input  corner_t                     wr_data,
  input  logic                        pop,
  output corner_t                     rd_data,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] free_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  corner_t        mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           wr_en;
  logic           rd_en;

  assign wr_en = push && (count != DEPTH_C);
  assign rd_en = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data  = mem[rd_ptr];
  assign empty    = (count == '0);
  assign free_cnt = DEPTH_C - count;

endmodule

// File: rtl/fast_frame_ctrl.sv
// fast_frame_ctrl: frame sequencer and output scheduler wrapping the FAST corner pipeline.
//   clk, rst            : clock, synchronous active-high reset
//   start, abort        : begin a frame from IDLE / cancel a running frame
//   busy, frame_done    : state != IDLE / one-cycle end-of-frame pulse
//   bus (slave)         : pixel stream in, corner stream out
//   pipe_ce/rst/data    : drive the FAST pipeline clock enable, clear and data_in
//   pipe_iscorner, pipe_xy_vld, pipe_x, pipe_y, pipe_score : pipeline results
//   corner_count        : corners written this frame (saturating)
//   stall_count         : cycles a ce was held off by a full FIFO
// Build option: define FAST_CTRL_STATS_EN to build the statistics counters;
// otherwise corner_count and stall_count are tied to zero.
module fast_frame_ctrl
  import fast_ctrl_pkg::*;
#(
  parameter int COL_NUM      = 640,
  parameter int ROW_NUM      = 480,
  parameter int PIXEL_WIDTH  = 8,
  parameter int DRAIN_CYCLES = 3*COL_NUM+16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    frame_done,
  fast_frame_ctrl_if.slave        bus,
  output logic                    pipe_ce,
  output logic                    pipe_rst,
  output logic [PIXEL_WIDTH-1:0]  pipe_data,
  input  logic                    pipe_iscorner,
  input  logic                    pipe_xy_vld,
  input  logic [9:0]              pipe_x,
  input  logic [9:0]              pipe_y,
  input  logic [12:0]             pipe_score,
  output logic [CORNER_CNT_W-1:0] corner_count,
  output logic [STALL_CNT_W-1:0]  stall_count
);

  localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PIX_CNT_W-1:0]   LAST_PIX   = PIX_CNT_W'(ROW_NUM*COL_NUM - 1);
  localparam logic [DRAIN_CNT_W-1:0] LAST_DRAIN = DRAIN_CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [FREE_W-1:0]      FREE_MIN   = FREE_W'(2);

  fast_ctrl_state_e        state_q, state_d;
  logic [PIX_CNT_W-1:0]    pix_cnt_q;
  logic [DRAIN_CNT_W-1:0]  drain_cnt_q;
  logic                    ce_p1;
  logic                    abort_p1;
  logic                    abort_hit;
  logic                    space_ok;
  logic                    s_ready;
  logic                    done;

  corner_t                 fifo_wr;
  corner_t                 fifo_rd;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_empty;
  logic [FREE_W-1:0]       fifo_free;

  assign abort_hit = abort && (state_q != ST_IDLE);
  // One slot stays reserved for the result of the ce issued last cycle.
  assign space_ok  = (fifo_free >= FREE_MIN);

  always_comb begin
    state_d   = state_q;
    s_ready   = 1'b0;
    pipe_ce   = 1'b0;
    pipe_data = '0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d = ST_FEED;
      end
      ST_FEED: begin
        s_ready   = space_ok;
        pipe_ce   = bus.s_pix_valid && space_ok;
        pipe_data = bus.s_pix_data;
        if (pipe_ce && (pix_cnt_q == LAST_PIX)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        pipe_ce = space_ok;
        if (pipe_ce && (drain_cnt_q == LAST_DRAIN)) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // ce_p1=0 means no pipeline result is still on its way to the FIFO.
        if (!ce_p1 && fifo_empty) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_hit) state_d = ST_IDLE;
  end

  // ---- stage p0 -> p1: state, counters and the registered ce ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pix_cnt_q   <= '0;
      drain_cnt_q <= '0;
      ce_p1       <= 1'b0;
      abort_p1    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ce_p1    <= pipe_ce && !abort_hit;
      abort_p1 <= abort_hit;
      if (state_q == ST_CLEAR) begin
        pix_cnt_q   <= '0;
        drain_cnt_q <= '0;
      end else begin
        if ((state_q == ST_FEED) && pipe_ce)  pix_cnt_q   <= pix_cnt_q + PIX_CNT_W'(1);
        if ((state_q == ST_DRAIN) && pipe_ce) drain_cnt_q <= drain_cnt_q + DRAIN_CNT_W'(1);
      end
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign frame_done = done && !abort;
  assign pipe_rst   = rst || (state_q == ST_CLEAR) || abort_p1;

  // ---- stage p1 -> FIFO: pipeline results qualified by the registered ce ----
  assign fifo_wr   = '{x: pipe_x, y: pipe_y, score: pipe_score};
  assign fifo_push = ce_p1 && pipe_xy_vld && pipe_iscorner;
  assign fifo_pop  = !fifo_empty && bus.m_ready;

  fast_corner_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (abort_hit),
    .push     (fifo_push),
    .wr_data  (fifo_wr),
    .pop      (fifo_pop),
    .rd_data  (fifo_rd),
    .empty    (fifo_empty),
    .free_cnt (fifo_free)
  );

  assign bus.s_pix_ready = s_ready;
  assign bus.m_valid     = !fifo_empty;
  // Storage is not reset, so the head is masked to zero while empty.
  assign bus.m_x         = fifo_empty ? 10'd0 : fifo_rd.x;
  assign bus.m_y         = fifo_empty ? 10'd0 : fifo_rd.y;
  assign bus.m_score     = fifo_empty ? 13'd0 : fifo_rd.score;

`ifdef FAST_CTRL_STATS_EN
  logic [CORNER_CNT_W-1:0] corner_cnt_q;
  logic [STALL_CNT_W-1:0]  stall_cnt_q;
  logic                    stall_req;

  function automatic logic [CORNER_CNT_W-1:0] sat_inc(input logic [CORNER_CNT_W-1:0] v);
    return (&v) ? v : v + CORNER_CNT_W'(1);
  endfunction

  // A ce was wanted (pixel offered, or draining) but the FIFO had no room.
  assign stall_req = !space_ok &&
                     (((state_q == ST_FEED) && bus.s_pix_valid) || (state_q == ST_DRAIN));

  always_ff @(posedge clk) begin
    if (rst || (state_q == ST_CLEAR)) begin
      corner_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (fifo_push) corner_cnt_q <= sat_inc(corner_cnt_q);
      if (stall_req) stall_cnt_q  <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign corner_count = corner_cnt_q;
  assign stall_count  = stall_cnt_q;
`else
  assign corner_count = '0;
  assign stall_count  = '0;
`endif

endmodule

// File: tb/tb_fast_frame_ctrl.sv
// tb_fast_frame_ctrl: directed bench for fast_frame_ctrl with a small FAST pipeline model.
module tb_fast_frame_ctrl;
  import fast_ctrl_pkg::*;

  localparam int COL_NUM = 16;
  localparam int ROW_NUM = 8;
  localparam int PW      = 8;
  localparam int DRAIN   = 64;
  localparam int DEPTH   = 4;
`ifdef FAST_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic        busy, frame_done;
  logic        pipe_ce, pipe_rst;
  logic [PW-1:0] pipe_data;
  logic        pipe_iscorner = 1'b0, pipe_xy_vld = 1'b0;
  logic [9:0]  pipe_x = '0, pipe_y = '0;
  logic [12:0] pipe_score = '0;
  logic [19:0] corner_count;
  logic [31:0] stall_count;

  always #5 clk = ~clk;

  fast_frame_ctrl_if #(.PIXEL_WIDTH(PW)) bus ();

  fast_frame_ctrl #(
    .COL_NUM(COL_NUM), .ROW_NUM(ROW_NUM), .PIXEL_WIDTH(PW),
    .DRAIN_CYCLES(DRAIN), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .frame_done(frame_done), .bus(bus),
    .pipe_ce(pipe_ce), .pipe_rst(pipe_rst), .pipe_data(pipe_data),
    .pipe_iscorner(pipe_iscorner), .pipe_xy_vld(pipe_xy_vld),
    .pipe_x(pipe_x), .pipe_y(pipe_y), .pipe_score(pipe_score),
    .corner_count(corner_count), .stall_count(stall_count)
  );

  // Pipeline model: results for ce number k appear the cycle after that ce.
  // mode 0: one corner (5,3,40) at ce 50; mode 1: a corner on every ce;
  // mode 2: one corner (1,2,3) at ce 138 (a drain ce); mode 3: no corners.
  int model_mode = 3;
  int ce_idx = 0;

  function automatic corner_t mode1_corner(input int i);
    corner_t c;
    c.x     = 10'(i);
    c.y     = 10'(i*3 + 1);
    c.score = 13'(i + 100);
    return c;
  endfunction

  always @(posedge clk) begin
    if (pipe_rst) begin
      ce_idx <= 0; pipe_xy_vld <= 1'b0; pipe_iscorner <= 1'b0;
      pipe_x <= '0; pipe_y <= '0; pipe_score <= '0;
    end else if (pipe_ce) begin
      ce_idx      <= ce_idx + 1;
      pipe_xy_vld <= 1'b1;
      case (model_mode)
        0: begin pipe_iscorner <= (ce_idx == 50); pipe_x <= 10'd5; pipe_y <= 10'd3; pipe_score <= 13'd40; end
        1: begin
          pipe_iscorner <= 1'b1;
          pipe_x <= mode1_corner(ce_idx).x; pipe_y <= mode1_corner(ce_idx).y;
          pipe_score <= mode1_corner(ce_idx).score;
        end
        2: begin pipe_iscorner <= (ce_idx == 138); pipe_x <= 10'd1; pipe_y <= 10'd2; pipe_score <= 13'd3; end
        default: pipe_iscorner <= 1'b0;
      endcase
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Cycle monitor: handshakes, drain ces, frame_done pulses and corner beats.
  int hs_cnt, drain_cnt, done_cnt, mon_err;
  corner_t beats[$];

  task automatic clear_mon();
    hs_cnt = 0; drain_cnt = 0; done_cnt = 0; mon_err = 0;
    beats.delete();
  endtask

  task automatic cyc();
    corner_t b;
    #1;
    if (bus.m_valid && bus.m_ready) begin
      b.x = bus.m_x; b.y = bus.m_y; b.score = bus.m_score;
      beats.push_back(b);
    end
    if (bus.s_pix_ready) begin
      if (pipe_ce !== bus.s_pix_valid) mon_err++;
      if (pipe_ce) begin
        hs_cnt++;
        if (pipe_data !== bus.s_pix_data) mon_err++;
      end
    end else if (pipe_ce) begin
      if (!busy) mon_err++;
      drain_cnt++;
      if (pipe_data !== '0) mon_err++;
    end
    if (frame_done) done_cnt++;
    @(negedge clk);
  endtask

  task automatic run_to_done(input bit toggle, input int budget);
    for (int k = 0; k < budget && done_cnt == 0; k++) begin
      if (toggle) bus.s_pix_valid = ~bus.s_pix_valid;
      bus.s_pix_data = 8'(k*7 + 3);
      cyc();
    end
  endtask

  task automatic basic_frame(input string tag);
    corner_t b;
    model_mode = 0; bus.m_ready = 1'b1; bus.s_pix_valid = 1'b1;
    clear_mon();
    start = 1'b1; cyc(); start = 1'b0;
    run_to_done(1'b0, 1000);
    b = (beats.size() > 0) ? beats[0] : '0;
    chk({tag, "_handshakes"}, hs_cnt, 128);
    chk({tag, "_drain_ce"}, drain_cnt, 64);
    chk({tag, "_frame_done"}, done_cnt, 1);
    chk({tag, "_beats"}, beats.size(), 1);
    chk({tag, "_beat"}, b, {10'd5, 10'd3, 13'd40});
    chk({tag, "_monitor_err"}, mon_err, 0);
    chk({tag, "_corner_count"}, corner_count, STATS ? 1 : 0);
    chk({tag, "_stall_count"}, stall_count, 0);
    #1 chk({tag, "_idle_after"}, busy, 0);
    @(negedge clk);
  endtask

  typedef struct {
    logic rst, start, abort, vld;
    logic [7:0] data;
    logic e_busy, e_rdy, e_ce, e_prst, e_done, e_mvld;
    logic [7:0] e_pdata;
  } vec_t;

  vec_t vt[11];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    corner_t b;
    int ord_err;
    //            rst   start abort vld   data  | busy  rdy   ce    prst  done  mvld  pdata
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h13};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h14};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h15};
    vt[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h16};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    bus.s_pix_valid = 1'b0; bus.s_pix_data = '0; bus.m_ready = 1'b1;
    @(negedge clk);

    // Reset state, start/abort priority in IDLE, CLEAR, FEED with gaps, start ignored in FEED.
    model_mode = 3;
    clear_mon();
    for (int i = 0; i < 11; i++) begin
      rst = vt[i].rst; start = vt[i].start; abort = vt[i].abort;
      bus.s_pix_valid = vt[i].vld; bus.s_pix_data = vt[i].data;
      #1;
      chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
      chk($sformatf("vec%0d_ready", i), bus.s_pix_ready, vt[i].e_rdy);
      chk($sformatf("vec%0d_ce", i), pipe_ce, vt[i].e_ce);
      chk($sformatf("vec%0d_pipe_rst", i), pipe_rst, vt[i].e_prst);
      chk($sformatf("vec%0d_done", i), frame_done, vt[i].e_done);
      chk($sformatf("vec%0d_m_valid", i), bus.m_valid, vt[i].e_mvld);
      chk($sformatf("vec%0d_pipe_data", i), pipe_data, vt[i].e_pdata);
      cyc();
    end
    start = 1'b0;
    if (1'b1) begin end

    // Source gaps: finish the same frame with valid toggling.
    run_to_done(1'b1, 2000);
    chk("gaps_handshakes", hs_cnt, 128);
    chk("gaps_drain_ce", drain_cnt, 64);
    chk("gaps_frame_done", done_cnt, 1);
    chk("gaps_beats", beats.size(), 0);
    chk("gaps_monitor_err", mon_err, 0);
    chk("gaps_corner_count", corner_count, 0);

    // Basic frame with constant valid and one corner.
    basic_frame("basic");

    // Backpressure: every ce produces a corner, sink stalled.
    model_mode = 1; bus.m_ready = 1'b0; bus.s_pix_valid = 1'b1;
    clear_mon();
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 0; k < 12; k++) cyc();
    #1;
    chk("bp_ce_before_stall", hs_cnt, 4);
    chk("bp_m_valid", bus.m_valid, 1);
    chk("bp_ready_low_full", bus.s_pix_ready, 0);
    chk("bp_head_x", bus.m_x, 0);
    chk("bp_stall_nonzero", stall_count != 0, STATS);
    @(negedge clk);
    bus.m_ready = 1'b1;
    run_to_done(1'b0, 2000);
    chk("bp_handshakes", hs_cnt, 128);
    chk("bp_drain_ce", drain_cnt, 64);
    chk("bp_frame_done", done_cnt, 1);
    chk("bp_beats", beats.size(), 192);
    for (int i = 0; i < 4; i++) begin
      b = (beats.size() > i) ? beats[i] : '0;
      chk($sformatf("bp_beat%0d", i), b, mode1_corner(i));
    end
    ord_err = 0;
    for (int i = 0; i < beats.size(); i++)
      if (beats[i] !== mode1_corner(i)) ord_err++;
    chk("bp_order_errors", ord_err, 0);
    chk("bp_corner_count", corner_count, STATS ? 192 : 0);

    // Abort in DRAIN after 20 drain ces, with one corner parked in the FIFO.
    model_mode = 2; bus.m_ready = 1'b0; bus.s_pix_valid = 1'b1;
    clear_mon();
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 0; k < 400 && drain_cnt < 20; k++) cyc();
    chk("abort_reached_drain20", drain_cnt, 20);
    #1 chk("abort_m_valid_before", bus.m_valid, 1);
    abort = 1'b1; cyc(); abort = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_pipe_rst", pipe_rst, 1);
    chk("abort_m_valid", bus.m_valid, 0);
    chk("abort_pipe_ce", pipe_ce, 0);
    @(negedge clk);
    for (int k = 0; k < 30; k++) cyc();
    chk("abort_no_frame_done", done_cnt, 0);
    chk("abort_pipe_rst_released", pipe_rst, 0);
    basic_frame("post_abort");

    // Reset in the middle of FEED with a full FIFO.
    model_mode = 1; bus.m_ready = 1'b0; bus.s_pix_valid = 1'b1;
    clear_mon();
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 0; k < 8; k++) cyc();
    #1 chk("rst_pre_m_valid", bus.m_valid, 1);
    rst = 1'b1; cyc();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", bus.s_pix_ready, 0);
    chk("rst_ce", pipe_ce, 0);
    chk("rst_pipe_rst", pipe_rst, 1);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_fields", {bus.m_x, bus.m_y, bus.m_score}, 0);
    chk("rst_pipe_data", pipe_data, 0);
    chk("rst_counters", {corner_count, stall_count}, 0);
    rst = 1'b0; cyc();
    #1;
    chk("rst_release_pipe_rst", pipe_rst, 0);
    chk("rst_release_m_valid", bus.m_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
